// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_pkg
//  Purpose  : Function-code constants and issue FSM state encoding. Shared by
//             the ALU issue controller and the ALU control decoder.
//  Revision : 1.0  initial release
// ============================================================================
package alu_issue_pkg;

   // TotalALU function codes
   localparam logic [5:0] c_fn_and   = 6'd36;
   localparam logic [5:0] c_fn_or    = 6'd37;
   localparam logic [5:0] c_fn_add   = 6'd32;
   localparam logic [5:0] c_fn_sub   = 6'd34;
   localparam logic [5:0] c_fn_slt   = 6'd42;
   localparam logic [5:0] c_fn_srl   = 6'd2;
   localparam logic [5:0] c_fn_multu = 6'd25;
   localparam logic [5:0] c_fn_divu  = 6'd27;
   localparam logic [5:0] c_fn_mfhi  = 6'd16;
   localparam logic [5:0] c_fn_mflo  = 6'd18;

   // Unused code parked on the ALU when nothing is in flight
   localparam logic [5:0] c_fn_idle  = 6'h3F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } issue_state_t;

endpackage : alu_issue_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Purpose  : Combinational opcode classifier for the issue controller.
//  Ports    : op        in  6  function code
//             legal     out 1  op is one of the ten supported codes
//             is_muldiv out 1  op is MULTU or DIVU (multi-cycle hold)
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_decode
   import alu_issue_pkg::*;
(
   input  logic [5:0] op,
   output logic       legal,
   output logic       is_muldiv
);

   always_comb begin
      legal     = 1'b0;
      is_muldiv = 1'b0;
      case (op)
         c_fn_and, c_fn_or, c_fn_add, c_fn_sub, c_fn_slt,
         c_fn_srl, c_fn_mfhi, c_fn_mflo: begin
            legal = 1'b1;
         end
         c_fn_multu, c_fn_divu: begin
            legal     = 1'b1;
            is_muldiv = 1'b1;
         end
         default: begin
            legal     = 1'b0;
            is_muldiv = 1'b0;
         end
      endcase
   end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Accepts one command at a time, holds its operands on the
//             TotalALU for a fixed number of cycles, then presents a
//             response until it is consumed.
//  Ports    : clk, reset (async, active-low)
//             cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b   command handshake
//             alu_dataA/alu_dataB/alu_signal/alu_result TotalALU interface
//             rsp_valid/rsp_ready/rsp_data/rsp_err     response handshake
//             busy                                     not IDLE
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int unsigned ALU_LAT   = 1,
   parameter int unsigned MD_CYCLES = 32,
   parameter logic [5:0]  IDLE_SIG  = c_fn_idle
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic [31:0] alu_dataA,
   output logic [31:0] alu_dataB,
   output logic [5:0]  alu_signal,
   input  logic [31:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy
);

   localparam logic [5:0] c_alu_cnt = 6'(ALU_LAT);
   localparam logic [5:0] c_md_cnt  = 6'(MD_CYCLES);

   issue_state_t state_q, state_d;
   logic [5:0]   cnt_q, cnt_d;
   logic [5:0]   op_q, op_d;
   logic [31:0]  a_q, a_d;
   logic [31:0]  b_q, b_d;
   logic         md_q, md_d;
   logic [31:0]  rsp_data_q, rsp_data_d;
   logic         rsp_err_q, rsp_err_d;

   logic         w_legal;
   logic         w_is_muldiv;

   alu_op_decode u_decode (
      .op        (cmd_op),
      .legal     (w_legal),
      .is_muldiv (w_is_muldiv)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      md_d       = md_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            // cmd_ready is simply "in IDLE", so cmd_valid alone means accept
            if (cmd_valid) begin
               if (w_legal) begin
                  state_d = ST_EXEC;
                  op_d    = cmd_op;
                  a_d     = cmd_a;
                  b_d     = cmd_b;
                  md_d    = w_is_muldiv;
                  cnt_d   = w_is_muldiv ? c_md_cnt : c_alu_cnt;
               end else begin
                  // Illegal ops never reach the ALU
                  state_d    = ST_RESP;
                  rsp_data_d = 32'd0;
                  rsp_err_d  = 1'b1;
               end
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d    = ST_RESP;
               // MULTU/DIVU only load HI/LO; their result is read by MFHI/MFLO
               rsp_data_d = md_q ? 32'd0 : alu_result;
               rsp_err_d  = 1'b0;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d    = ST_IDLE;
               rsp_data_d = 32'd0;
               rsp_err_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 6'd0;
         op_q       <= 6'd0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         md_q       <= 1'b0;
         rsp_data_q <= 32'd0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         md_q       <= md_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // ALU is only driven while an op is executing; parked otherwise
   assign alu_dataA  = (state_q == ST_EXEC) ? a_q  : 32'd0;
   assign alu_dataB  = (state_q == ST_EXEC) ? b_q  : 32'd0;
   assign alu_signal = (state_q == ST_EXEC) ? op_q : IDLE_SIG;

   assign cmd_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;

endmodule : alu_issue_ctrl
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Purpose  : Self-checking bench for alu_issue_ctrl with a TotalALU stub
//             and a behavioural reference for results and latencies.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;
   import alu_issue_pkg::*;

   localparam int MD_N = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b;
   logic [31:0] alu_dataA, alu_dataB;
   logic [5:0]  alu_signal;
   logic [31:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.ALU_LAT(1), .MD_CYCLES(MD_N), .IDLE_SIG(6'h3F)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy)
   );

   // ---------------- TotalALU stub ----------------
   logic [31:0] s_hi = 32'd0;
   logic [31:0] s_lo = 32'd0;

   always_comb begin
      alu_result = 32'd0;
      case (alu_signal)
         6'd36: alu_result = alu_dataA & alu_dataB;
         6'd37: alu_result = alu_dataA | alu_dataB;
         6'd32: alu_result = alu_dataA + alu_dataB;
         6'd34: alu_result = alu_dataA - alu_dataB;
         6'd42: alu_result = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
         6'd2:  alu_result = alu_dataA >> alu_dataB[4:0];
         6'd16: alu_result = s_hi;
         6'd18: alu_result = s_lo;
         default: alu_result = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (alu_signal == 6'd25) begin
         {s_hi, s_lo} <= 64'(alu_dataA) * 64'(alu_dataB);
      end else if (alu_signal == 6'd27 && alu_dataB != 32'd0) begin
         s_lo <= alu_dataA / alu_dataB;
         s_hi <= alu_dataA % alu_dataB;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   function automatic bit ref_legal(input logic [5:0] op);
      int codes [10] = '{36, 37, 32, 34, 42, 2, 25, 27, 16, 18};
      foreach (codes[i]) if (int'(op) == codes[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit ref_md(input logic [5:0] op);
      return (op == 6'd25) || (op == 6'd27);
   endfunction

   function automatic int ref_lat(input logic [5:0] op);
      if (!ref_legal(op)) return 0;
      return ref_md(op) ? MD_N : 1;
   endfunction

   function automatic logic [31:0] ref_data(input logic [5:0] op, input logic [31:0] a, b,
                                            input logic [31:0] hi, lo);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (int'(op))
         36: return a & b;
         37: return a | b;
         32: return a + b;
         34: return a - b;
         42: return (sa < sb) ? 32'd1 : 32'd0;
         2:  return a >> (b % 32);
         16: return hi;
         18: return lo;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_update(input logic [5:0] op, input logic [31:0] a, b);
      logic [63:0] p;
      if (op == 6'd25) begin
         p = 64'(a) * 64'(b);
         m_hi = p[63:32];
         m_lo = p[31:0];
      end else if (op == 6'd27 && b != 32'd0) begin
         m_lo = a / b;
         m_hi = a % b;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one full transaction; reports latency, response and counts of
   // cycles where the ALU drive or the held response looked wrong.
   task automatic run_op(input logic [5:0] op, input logic [31:0] a, b,
                         input int hold, input bit poke,
                         output int lat, output logic [31:0] data, output logic err,
                         output int exec_bad, output int hold_bad);
      int w;
      lat = 0; exec_bad = 0; hold_bad = 0; w = 0;
      while (!cmd_ready && w < 100) begin step(); w++; end
      if (!cmd_ready) exec_bad++;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      step();
      cmd_valid = 1'b0;
      cmd_op = 6'($urandom); cmd_a = $urandom; cmd_b = $urandom;
      while (!rsp_valid && lat < 200) begin
         if (alu_signal !== op || alu_dataA !== a || alu_dataB !== b ||
             busy !== 1'b1 || cmd_ready !== 1'b0) exec_bad++;
         step();
         lat++;
      end
      data = rsp_data;
      err  = rsp_err;
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) step();
         if (poke) begin
            cmd_valid = 1'b1; cmd_op = 6'd32; cmd_a = $urandom; cmd_b = $urandom;
         end
         if (rsp_valid !== 1'b1 || rsp_data !== data || rsp_err !== err ||
             cmd_ready !== 1'b0 || busy !== 1'b1 || alu_signal !== 6'h3F ||
             alu_dataA !== 32'd0 || alu_dataB !== 32'd0) hold_bad++;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 6'd0; cmd_a = 32'd0; cmd_b = 32'd0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++;
         $display("FAIL reset_ready_busy: got ready=%0b busy=%0b want 1 0", cmd_ready, busy); end
      checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin errors++;
         $display("FAIL reset_rsp: got v=%0b d=%h e=%0b want 0 0 0", rsp_valid, rsp_data, rsp_err); end
      checks++; if (alu_signal !== 6'h3F || alu_dataA !== 32'd0 || alu_dataB !== 32'd0) begin errors++;
         $display("FAIL reset_alu: got sig=%h a=%h b=%h want 3f 0 0", alu_signal, alu_dataA, alu_dataB); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_add();
      int lat, xb, hb; logic [31:0] d; logic e;
      run_op(6'd32, 32'd5, 32'd7, 0, 1'b0, lat, d, e, xb, hb);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
      checks++; if (d !== 32'd12 || e !== 1'b0) begin errors++;
         $display("FAIL add_data: got %h err=%0b want 0000000c err=0", d, e); end
      checks++; if (xb != 0 || hb != 0) begin errors++;
         $display("FAIL add_drive: got exec_bad=%0d hold_bad=%0d want 0 0", xb, hb); end
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
         $display("FAIL add_after: got v=%0b ready=%0b want 0 1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_sub_slt();
      int lat, xb, hb; logic [31:0] d; logic e;
      run_op(6'd34, 32'd3, 32'd5, 0, 1'b0, lat, d, e, xb, hb);
      checks++; if (d !== 32'hFFFF_FFFE || e !== 1'b0 || lat != 1) begin errors++;
         $display("FAIL sub: got %h err=%0b lat=%0d want fffffffe 0 1", d, e, lat); end
      run_op(6'd42, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, lat, d, e, xb, hb);
      checks++; if (d !== 32'd1 || e !== 1'b0 || lat != 1) begin errors++;
         $display("FAIL slt: got %h err=%0b lat=%0d want 00000001 0 1", d, e, lat); end
   endtask

   task automatic test_muldiv();
      int lat, xb, hb; logic [31:0] d; logic e;
      run_op(6'd25, 32'd6, 32'd7, 0, 1'b0, lat, d, e, xb, hb);
      model_update(6'd25, 32'd6, 32'd7);
      checks++; if (lat != MD_N || xb != 0) begin errors++;
         $display("FAIL multu_hold: got lat=%0d exec_bad=%0d want %0d 0", lat, xb, MD_N); end
      checks++; if (d !== 32'd0 || e !== 1'b0) begin errors++;
         $display("FAIL multu_data: got %h err=%0b want 0 0", d, e); end
      run_op(6'd18, 32'd0, 32'd0, 0, 1'b0, lat, d, e, xb, hb);
      checks++; if (d !== 32'd42) begin errors++; $display("FAIL mflo: got %h want 0000002a", d); end
      run_op(6'd16, 32'd0, 32'd0, 0, 1'b0, lat, d, e, xb, hb);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL mfhi: got %h want 0", d); end
   endtask

   task automatic test_backpressure();
      int lat, xb, hb; logic [31:0] d; logic e; int extra;
      run_op(6'd32, 32'd9, 32'd10, 5, 1'b1, lat, d, e, xb, hb);
      checks++; if (d !== 32'd19 || hb != 0) begin errors++;
         $display("FAIL bp_hold: got d=%h hold_bad=%0d want 00000013 0", d, hb); end
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid !== 1'b0 || busy !== 1'b0) extra++;
         step();
      end
      checks++; if (extra != 0) begin errors++;
         $display("FAIL bp_ignored_cmd: got %0d active cycles want 0", extra); end
   endtask

   task automatic test_illegal();
      int lat, xb, hb; logic [31:0] d; logic e;
      run_op(6'h3E, 32'd1, 32'd2, 1, 1'b0, lat, d, e, xb, hb);
      checks++; if (lat != 0 || e !== 1'b1 || d !== 32'd0) begin errors++;
         $display("FAIL illegal: got lat=%0d err=%0b d=%h want 0 1 0", lat, e, d); end
      checks++; if (hb != 0) begin errors++;
         $display("FAIL illegal_alu_idle: got hold_bad=%0d want 0", hb); end
   endtask

   task automatic test_reset_mid_exec();
      int w, late; int lat, xb, hb; logic [31:0] d; logic e;
      w = 0;
      while (!cmd_ready && w < 100) begin step(); w++; end
      cmd_valid = 1'b1; cmd_op = 6'd27; cmd_a = 32'd100; cmd_b = 32'd7;
      step();
      cmd_valid = 1'b0;
      repeat (9) step();
      checks++; if (busy !== 1'b1 || alu_signal !== 6'd27) begin errors++;
         $display("FAIL divu_in_exec: got busy=%0b sig=%h want 1 1b", busy, alu_signal); end
      model_update(6'd27, 32'd100, 32'd7);
      #1 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
                    rsp_data !== 32'd0 || rsp_err !== 1'b0 || alu_signal !== 6'h3F ||
                    alu_dataA !== 32'd0 || alu_dataB !== 32'd0) begin errors++;
         $display("FAIL async_reset: got busy=%0b rdy=%0b v=%0b d=%h e=%0b sig=%h a=%h b=%h want 0 1 0 0 0 3f 0 0",
                  busy, cmd_ready, rsp_valid, rsp_data, rsp_err, alu_signal, alu_dataA, alu_dataB); end
      @(negedge clk);
      reset = 1'b1;
      late = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (rsp_valid !== 1'b0 || busy !== 1'b0) late++;
      end
      checks++; if (late != 0) begin errors++;
         $display("FAIL reset_abandon: got %0d active cycles want 0", late); end
      run_op(6'd18, 32'd0, 32'd0, 0, 1'b0, lat, d, e, xb, hb);
      checks++; if (d !== m_lo) begin errors++; $display("FAIL post_reset_mflo: got %h want %h", d, m_lo); end
   endtask

   task automatic test_random();
      logic [5:0] ops [10] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd27, 6'd16, 6'd18};
      logic [5:0] op; logic [31:0] a, b, exp_d; bit exp_e; int exp_l;
      int lat, xb, hb; logic [31:0] d; logic e;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            op = 6'($urandom);
            while (ref_legal(op)) op = 6'($urandom);
         end else if ($urandom_range(0, 3) == 0) begin
            op = ops[$urandom_range(0, 9)];
         end else begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 2) == 0) op = ops[8 + $urandom_range(0, 1)];
         end
         a = $urandom; b = $urandom;
         if (op == 6'd27 && b == 32'd0) b = 32'd1;
         exp_l = ref_lat(op);
         exp_e = !ref_legal(op);
         exp_d = (exp_e || ref_md(op)) ? 32'd0 : ref_data(op, a, b, m_hi, m_lo);
         run_op(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, d, e, xb, hb);
         if (!exp_e) model_update(op, a, b);
         checks++; if (lat != exp_l || d !== exp_d || e !== exp_e || xb != 0 || hb != 0) begin errors++;
            $display("FAIL rand[%0d] op=%0d a=%h b=%h: got lat=%0d d=%h e=%0b xb=%0d hb=%0d want lat=%0d d=%h e=%0b",
                     n, op, a, b, lat, d, e, xb, hb, exp_l, exp_d, exp_e); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_sub_slt();
      test_muldiv();
      test_backpressure();
      test_illegal();
      test_reset_mid_exec();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_issue_ctrl
`default_nettype wire
